// File: rtl/mips_fetch_pkg.sv
// Shared fetch-path constants for the single-cycle MIPS core: opcode/funct
// encodings that steer the PC and the sequencer state encoding.
package mips_fetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer (master) and the rest of the
// core (slave): decoded-instruction inputs in, PC and commit qualifiers out.
interface pc_sequencer_if;
  logic [31:0] instruction;
  logic        zero;
  logic [31:0] rs_data;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        redirect;
  logic        halted;

  modport master (
    input  instruction, zero, rs_data, stall,
    output PC, pc_plus4, inst_valid, redirect, halted
  );

  modport slave (
    output instruction, zero, rs_data, stall,
    input  PC, pc_plus4, inst_valid, redirect, halted
  );
endinterface

// File: rtl/next_pc_calc.sv
// Purely combinational successor-PC decode: computes PC+4, the selected
// control-transfer target, whether it is taken, and whether this is a break.
module next_pc_calc
  import mips_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        taken,
  output logic        is_break
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
  // jr ignores misaligned low bits of the register value.
  assign jr_target     = {rs_data[31:2], 2'b00};

  always_comb begin
    taken    = 1'b0;
    target   = pc_plus4;
    is_break = 1'b0;
    case (opcode)
      OP_BEQ: begin
        taken  = zero;
        target = branch_target;
      end
      OP_BNE: begin
        taken  = ~zero;
        target = branch_target;
      end
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = jump_target;
      end
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          taken  = 1'b1;
          target = jr_target;
        end else if (funct == FN_BREAK) begin
          is_break = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC register and BOOT/RUN/HALT FSM.
// Define PC_SEQ_DELAY_SLOT_EN to enable a one-instruction branch delay slot.
module pc_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00400020
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.master bus
);

  seq_state_e  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        taken;
  logic        is_break;
  logic        inst_valid;
  logic        redirect;

`ifdef PC_SEQ_DELAY_SLOT_EN
  logic [31:0] pend_reg, pend_next;
  logic        pend_valid_reg, pend_valid_next;
`endif

  next_pc_calc u_calc (
    .pc          (pc_reg),
    .instruction (bus.instruction),
    .zero        (bus.zero),
    .rs_data     (bus.rs_data),
    .pc_plus4    (pc_plus4),
    .target      (target),
    .taken       (taken),
    .is_break    (is_break)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

`ifdef PC_SEQ_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg       <= 32'd0;
      pend_valid_reg <= 1'b0;
    end else begin
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_valid = 1'b0;
    redirect   = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
`endif
    // A stall freezes everything, including any pending delay-slot target.
    if (!bus.stall) begin
      case (state_reg)
        BOOT: state_next = RUN;
        RUN: begin
          inst_valid = 1'b1;
          if (is_break) begin
            state_next = HALT;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pend_valid_next = 1'b0;
          end else if (pend_valid_reg) begin
            // Delay-slot instruction: its own transfers are ignored.
            redirect        = 1'b1;
            pc_next         = pend_reg;
            pend_valid_next = 1'b0;
          end else if (taken) begin
            pend_next       = target;
            pend_valid_next = 1'b1;
            pc_next         = pc_plus4;
`else
          end else if (taken) begin
            redirect = 1'b1;
            pc_next  = target;
`endif
          end else begin
            pc_next = pc_plus4;
          end
        end
        HALT: ;
        default: state_next = BOOT;
      endcase
    end
  end

  assign bus.PC         = pc_reg;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.inst_valid = inst_valid;
  assign bus.redirect   = redirect;
  assign bus.halted     = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver pushes model-predicted outputs
// per cycle, a monitor pops and compares them against the DUT.
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        redir;
    logic        halt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h00400020)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: architectural view only.
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_known = 0;
  bit          m_boot, m_halt, m_pend_v;

  task automatic step(input logic [31:0] instr, input logic z,
                      input logic [31:0] rs, input logic st, input logic rst);
    logic [5:0]  op, fn;
    logic        valid, take, brk, redir;
    logic [31:0] tgt, off;
    exp_t        e;
    @(negedge clk);
    bus.instruction = instr;
    bus.zero        = z;
    bus.rs_data     = rs;
    bus.stall       = st;
    reset           = rst;
    if (m_known) begin
      op    = instr[31:26];
      fn    = instr[5:0];
      valid = !m_boot && !m_halt && !st;
      take  = 1'b0;
      brk   = 1'b0;
      tgt   = 32'd0;
      off   = 32'($signed(instr[15:0])) * 4;
      if (op == 6'h04) begin take = z;  tgt = m_pc + 4 + off; end
      if (op == 6'h05) begin take = !z; tgt = m_pc + 4 + off; end
      if (op == 6'h02 || op == 6'h03) begin
        take = 1'b1;
        tgt  = ((m_pc + 4) & 32'hF000_0000) | (32'(instr[25:0]) * 4);
      end
      if (op == 6'h00 && fn == 6'h08) begin take = 1'b1; tgt = rs & ~32'd3; end
      if (op == 6'h00 && fn == 6'h0D) brk = 1'b1;
`ifdef PC_SEQ_DELAY_SLOT_EN
      redir = valid && m_pend_v && !brk;
`else
      redir = valid && take;
`endif
      e.pc = m_pc; e.pc4 = m_pc + 4; e.valid = valid; e.redir = redir; e.halt = m_halt;
      exp_q.push_back(e);
      if (!rst && !st) begin
        if (m_boot) m_boot = 0;
        else if (!m_halt) begin
          if (brk) begin
            m_halt = 1; m_pend_v = 0;
          end else begin
`ifdef PC_SEQ_DELAY_SLOT_EN
            if (m_pend_v) begin m_pc = m_pend; m_pend_v = 0; end
            else if (take) begin m_pend = tgt; m_pend_v = 1; m_pc = m_pc + 4; end
            else m_pc = m_pc + 4;
`else
            m_pc = take ? tgt : m_pc + 4;
`endif
          end
        end
      end
    end
    if (rst) begin
      m_known = 1; m_pc = 32'h00400020; m_boot = 1; m_halt = 0; m_pend_v = 0; m_pend = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %h expected %h", name, vectors, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check("pc",         bus.PC,                 e.pc);
        check("pc_plus4",   bus.pc_plus4,           e.pc4);
        check("inst_valid", 32'(bus.inst_valid),    32'(e.valid));
        check("redirect",   32'(bus.redirect),      32'(e.redir));
        check("halted",     32'(bus.halted),        32'(e.halt));
        $display("vec %0d pc=%h v=%0b r=%0b h=%0b", vectors, bus.PC,
                 bus.inst_valid, bus.redirect, bus.halted);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0, 1, 2, 3: return {6'h00, r[25:6], 6'h20};
      4, 5:       return {6'h04, r[25:0]};
      6, 7:       return {6'h05, r[25:0]};
      8:          return {6'h02, r[25:0]};
      9:          return {6'h03, r[25:0]};
      10:         return {6'h00, r[25:6], 6'h08};
      11:         return ($urandom_range(0, 3) == 0) ? {6'h00, r[25:6], 6'h0D} : 32'd0;
      12, 13:     return {($urandom_range(0, 1) == 0) ? 6'h08 : 6'h23, r[25:0]};
      default:    return r;
    endcase
  endfunction

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] BEQ19 = 32'h1000_0019;
  localparam logic [31:0] J104  = 32'h0810_0041;
  localparam logic [31:0] JR    = 32'h03E0_0008;
  localparam logic [31:0] BRK   = 32'h0000_000D;

  initial begin : driver
    bus.instruction = NOP; bus.zero = 0; bus.rs_data = 0; bus.stall = 0; reset = 1;
    step(NOP, 0, 0, 0, 1);
    step(NOP, 0, 0, 0, 0);                // BOOT at 0x00400020
    step(NOP, 0, 0, 0, 0);                // 0x00400020
    step(NOP, 0, 0, 0, 0);                // 0x00400024
    step(BEQ19, 1, 0, 0, 0);              // 0x00400028 taken
    step(J104, 0, 0, 0, 0);               // 0x00400090 (or delay slot)
    step(J104, 0, 0, 0, 0);
    step(JR, 0, 32'h00400027, 0, 0);
    step(NOP, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(NOP, 0, 0, 1, 0);
    step(NOP, 0, 0, 0, 0);
    step(BEQ19, 0, 0, 0, 0);              // not-taken beq
    step(JR, 0, 32'hFFFF_FFFE, 0, 0);     // wrap target
    for (int i = 0; i < 3; i++) step(NOP, 0, 0, 0, 0);
    step(J104, 0, 0, 0, 0);
    step(NOP, 0, 0, 0, 0);
    step(BRK, 0, 0, 1, 0);                // break under stall: no effect
    step(BRK, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(rand_instr(), 1'($urandom), $urandom, 1'($urandom), 0);
    step(NOP, 0, 0, 1, 1);                // reset while stalled in HALT
    for (int i = 0; i < 3000; i++) begin
      step(rand_instr(), 1'($urandom), $urandom, $urandom_range(0, 4) == 0,
           ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
